// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
// Holds requester ids, memory op encoding and the read-return stage record.
package ram_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  // One in-flight read: which requester owns the data arriving next cycle.
  typedef struct packed {
    logic    vld;
    req_id_e id;
  } rd_stage_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester A/B handshakes plus the RAM-side bus of the port arbiter.
// master = arbiter side, slave = requesters and RAM environment.
interface ram_port_arbiter_if #(
  parameter int AW = ram_arb_pkg::AW_DEF,
  parameter int DW = ram_arb_pkg::DW_DEF
) ();

  logic          req_a,    req_b;
  logic          we_a,     we_b;
  logic [AW-1:0] addr_a,   addr_b;
  logic [DW-1:0] wdata_a,  wdata_b;
  logic          gnt_a,    gnt_b;
  logic          rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a,  rdata_b;

  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output mem_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  mem_en, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant, combinational from req; prio register points at the loser.
// Zero latency; a requester not granted simply keeps requesting.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e prio_q, prio_d;

  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | (prio_q == ID_A));
    gnt_o[1] = req_i[1] & (~req_i[0] | (prio_q == ID_B));
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = ID_B;
    end else if (gnt_o[1]) begin
      prio_d = ID_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= ID_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a 1-cycle-latency single-port RAM between requesters A and B, one access per cycle.
// Reads return 2 cycles after grant; losers are held off by gnt and must keep requesting.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.master bus
);

  logic [1:0] req;
  logic [1:0] gnt;

  // Masking requests during reset keeps gnt and mem_en low without extra gating.
  assign req = {bus.req_b & rst, bus.req_a & rst};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .gnt_o (gnt)
  );

  mem_op_e       op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always_comb begin
    op        = OP_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      op        = mem_op_e'(bus.we_a);
      mem_addr  = bus.addr_a;
      mem_wdata = bus.wdata_a;
    end else if (gnt[1]) begin
      op        = mem_op_e'(bus.we_b);
      mem_addr  = bus.addr_b;
      mem_wdata = bus.wdata_b;
    end
  end

  assign bus.gnt_a     = gnt[0];
  assign bus.gnt_b     = gnt[1];
  assign bus.mem_en    = (op == OP_WRITE);
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  rd_stage_t     stage_q, stage_d;
  logic          rvalid_a_q, rvalid_a_d;
  logic          rvalid_b_q, rvalid_b_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;

  always_comb begin
    stage_d.vld = (|gnt) & (op == OP_READ);
    stage_d.id  = gnt[1] ? ID_B : ID_A;

    rvalid_a_d = stage_q.vld & (stage_q.id == ID_A);
    rvalid_b_d = stage_q.vld & (stage_q.id == ID_B);
    rdata_a_d  = rvalid_a_d ? bus.mem_rdata : rdata_a_q;
    rdata_b_d  = rvalid_b_d ? bus.mem_rdata : rdata_b_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q    <= '{vld: 1'b0, id: ID_A};
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      stage_q    <= stage_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed table of per-cycle inputs and expected outputs for ram_port_arbiter,
// with a behavioural 1024x8 RAM on the memory side.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  ram_port_arbiter_if #(.AW(10), .DW(8)) bus ();

  ram_port_arbiter #(.AW(10), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [1024];

  always @(posedge clk) begin
    if (bus.mem_en) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    bit         rst;
    bit         ra;
    bit         wa;
    logic [9:0] aa;
    logic [7:0] da;
    bit         rb;
    bit         wb;
    logic [9:0] ab;
    logic [7:0] db;
    bit         ga;
    bit         gb;
    bit         me;
    logic [9:0] ma;
    logic [7:0] md;
    bit         va;
    bit         vb;
    logic [7:0] xa;
    logic [7:0] xb;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t mk(bit r, bit ra, bit wa, logic [9:0] aa, logic [7:0] da,
                              bit rb, bit wb, logic [9:0] ab, logic [7:0] db,
                              bit ga, bit gb, bit me, logic [9:0] ma, logic [7:0] md,
                              bit va, bit vb, logic [7:0] xa, logic [7:0] xb);
    vec_t v;
    v.rst = r;  v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
    v.rb = rb;  v.wb = wb; v.ab = ab; v.db = db;
    v.ga = ga;  v.gb = gb; v.me = me; v.ma = ma; v.md = md;
    v.va = va;  v.vb = vb; v.xa = xa; v.xb = xb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    rst          = v.rst;
    bus.req_a    = v.ra;  bus.we_a = v.wa;  bus.addr_a = v.aa;  bus.wdata_a = v.da;
    bus.req_b    = v.rb;  bus.we_b = v.wb;  bus.addr_b = v.ab;  bus.wdata_b = v.db;
    #1;
    check({tag, " gnt_a"},     32'(bus.gnt_a),     32'(v.ga));
    check({tag, " gnt_b"},     32'(bus.gnt_b),     32'(v.gb));
    check({tag, " mem_en"},    32'(bus.mem_en),    32'(v.me));
    check({tag, " mem_addr"},  32'(bus.mem_addr),  32'(v.ma));
    check({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(v.md));
    check({tag, " rvalid_a"},  32'(bus.rvalid_a),  32'(v.va));
    check({tag, " rvalid_b"},  32'(bus.rvalid_b),  32'(v.vb));
    check({tag, " rdata_a"},   32'(bus.rdata_a),   32'(v.xa));
    check({tag, " rdata_b"},   32'(bus.rdata_b),   32'(v.xb));
  endtask

  vec_t tbl [18];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    rst = 1'b0;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;

    //             rst ra wa aa      da     rb wb ab      db     ga gb me ma      md     va vb xa     xb
    tbl[0]  = mk(0, 1, 0, 10'h001, 8'h00, 1, 0, 10'h002, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[1]  = mk(0, 1, 0, 10'h001, 8'h00, 1, 0, 10'h002, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[2]  = mk(0, 1, 0, 10'h001, 8'h00, 1, 0, 10'h002, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    // Out of reset A is favoured; then B's held write, then A reads what B just wrote.
    tbl[3]  = mk(1, 1, 1, 10'h3FF, 8'hA5, 1, 1, 10'h010, 8'h11, 1, 0, 1, 10'h3FF, 8'hA5, 0, 0, 8'h00, 8'h00);
    tbl[4]  = mk(1, 1, 0, 10'h010, 8'h00, 1, 1, 10'h010, 8'h11, 0, 1, 1, 10'h010, 8'h11, 0, 0, 8'h00, 8'h00);
    tbl[5]  = mk(1, 1, 0, 10'h010, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 10'h010, 8'h00, 0, 0, 8'h00, 8'h00);
    tbl[6]  = mk(1, 1, 1, 10'h000, 8'hFF, 0, 0, 10'h000, 8'h00, 1, 0, 1, 10'h000, 8'hFF, 0, 0, 8'h00, 8'h00);
    tbl[7]  = mk(1, 0, 0, 10'h000, 8'h00, 1, 1, 10'h3FF, 8'h00, 0, 1, 1, 10'h3FF, 8'h00, 1, 0, 8'h11, 8'h00);
    // Six cycles of dual read requests: A,B,A,B,A,B.
    tbl[8]  = mk(1, 1, 0, 10'h000, 8'h00, 1, 0, 10'h3FF, 8'h00, 1, 0, 0, 10'h000, 8'h00, 0, 0, 8'h11, 8'h00);
    tbl[9]  = mk(1, 1, 0, 10'h3FF, 8'h00, 1, 0, 10'h3FF, 8'h00, 0, 1, 0, 10'h3FF, 8'h00, 0, 0, 8'h11, 8'h00);
    tbl[10] = mk(1, 1, 0, 10'h3FF, 8'h00, 1, 0, 10'h000, 8'h00, 1, 0, 0, 10'h3FF, 8'h00, 1, 0, 8'hFF, 8'h00);
    tbl[11] = mk(1, 1, 0, 10'h010, 8'h00, 1, 0, 10'h000, 8'h00, 0, 1, 0, 10'h000, 8'h00, 0, 1, 8'hFF, 8'h00);
    tbl[12] = mk(1, 1, 0, 10'h010, 8'h00, 1, 0, 10'h010, 8'h00, 1, 0, 0, 10'h010, 8'h00, 1, 0, 8'h00, 8'h00);
    tbl[13] = mk(1, 1, 0, 10'h3FF, 8'h00, 1, 0, 10'h010, 8'h00, 0, 1, 0, 10'h010, 8'h00, 0, 1, 8'h00, 8'hFF);
    tbl[14] = mk(1, 1, 0, 10'h3FF, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 10'h3FF, 8'h00, 1, 0, 8'h11, 8'hFF);
    tbl[15] = mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 1, 8'h11, 8'h11);
    tbl[16] = mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 1, 0, 8'h00, 8'h11);
    tbl[17] = mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h11);

    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      run_vec(tbl[i], $sformatf("row%0d", i));
    end

    // Reset one cycle after a B read grant: the read is dropped and rdata clears.
    run_vec(mk(1, 0, 0, 10'h000, 8'h00, 1, 0, 10'h000, 8'h00, 0, 1, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h11), "rst_mid s1");
    run_vec(mk(0, 1, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h11), "rst_mid s2");
    run_vec(mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00), "rst_mid s3");
    run_vec(mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00), "rst_mid s4");

    // A grant moves prio to B; reset must bring it back to A.
    run_vec(mk(1, 1, 0, 10'h3FF, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 10'h3FF, 8'h00, 0, 0, 8'h00, 8'h00), "prio_rst s1");
    run_vec(mk(0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00), "prio_rst s2");
    run_vec(mk(1, 1, 0, 10'h3FF, 8'h00, 1, 0, 10'h000, 8'h00, 1, 0, 0, 10'h3FF, 8'h00, 0, 0, 8'h00, 8'h00), "prio_rst s3");
    run_vec(mk(1, 0, 0, 10'h000, 8'h00, 1, 0, 10'h000, 8'h00, 0, 1, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'h00), "prio_rst s4");
    run_vec(mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 1, 0, 8'h00, 8'h00), "prio_rst s5");
    run_vec(mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 1, 8'h00, 8'hFF), "prio_rst s6");
    run_vec(mk(1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0, 8'h00, 8'hFF), "prio_rst s7");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
